// File: rtl/lsq_sq_param.sv
// lsq_sq_param: parametrised store queue with byte-enable forwarding, branch squash and split retire/drain pointers
// Ports: dp_* allocate at tail (sq_tail_o/full/empty report occupancy); st_* resolve an entry's address/data/be;
//        rob_st_retire_i advances the commit pointer; dc_st_* drain retired head entries to the Dcache;
//        ld_q_* query older stores combinationally (unknown/forward/conflict); br_* restore a tail
//        checkpoint or clear a resolved branch tag.
// Build option: define SQ_STLD_FWD_EN to enable store-to-load forwarding; without it any overlapping
//        older address match reports a conflict and forwarding outputs stay 0.
module lsq_sq_param #(
  parameter int SQ_DEPTH = 8,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int BR_MASK_W = 4,
  parameter int IDX_W = $clog2(SQ_DEPTH),
  localparam int BE_W = DATA_W / 8,
  localparam int PW = IDX_W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dp_en_i,
  input  logic [BR_MASK_W-1:0] dp_br_mask_i,
  output logic [PW-1:0]        sq_tail_o,
  output logic                 sq_full_o,
  output logic                 sq_empty_o,
  input  logic                 st_vld_i,
  input  logic [IDX_W-1:0]     st_idx_i,
  input  logic [ADDR_W-1:0]    st_addr_i,
  input  logic [DATA_W-1:0]    st_data_i,
  input  logic [BE_W-1:0]      st_be_i,
  input  logic                 rob_st_retire_i,
  output logic                 dc_st_req_o,
  output logic [ADDR_W-1:0]    dc_st_addr_o,
  output logic [DATA_W-1:0]    dc_st_data_o,
  output logic [BE_W-1:0]      dc_st_be_o,
  input  logic                 dc_st_ack_i,
  input  logic                 ld_q_vld_i,
  input  logic [ADDR_W-1:0]    ld_q_addr_i,
  input  logic [BE_W-1:0]      ld_q_be_i,
  input  logic [PW-1:0]        ld_q_pos_i,
  output logic                 ld_older_unknown_o,
  output logic                 ld_fwd_vld_o,
  output logic [DATA_W-1:0]    ld_fwd_data_o,
  output logic                 ld_conflict_o,
  input  logic                 br_recover_i,
  input  logic [PW-1:0]        br_sq_tail_i,
  input  logic                 br_correct_i,
  input  logic [BR_MASK_W-1:0] br_tag_i
);
  logic [PW-1:0] r_head, r_commit, r_tail;
  logic [SQ_DEPTH-1:0] r_addr_vld, r_retired;
  logic [ADDR_W-1:0] r_addr [SQ_DEPTH];
  logic [DATA_W-1:0] r_data [SQ_DEPTH];
  logic [BE_W-1:0] r_be [SQ_DEPTH];
  logic [BR_MASK_W-1:0] r_br_mask [SQ_DEPTH];
  logic w_full, w_disp, w_retire, w_drain;
  logic [SQ_DEPTH-1:0] w_disp_v, w_res_v, w_ret_v, w_drn_v, w_sq_v;
  logic w_unknown, w_conf, w_done;
  logic [IDX_W-1:0] w_j;
  logic [PW-1:0] w_n;
  assign w_full = (r_tail[IDX_W] != r_head[IDX_W]) && (r_tail[IDX_W-1:0] == r_head[IDX_W-1:0]);
  assign sq_full_o = w_full;
  assign sq_empty_o = r_tail == r_head;
  assign sq_tail_o = r_tail;
  assign dc_st_req_o = r_head != r_commit;
  assign dc_st_addr_o = r_addr[r_head[IDX_W-1:0]];
  assign dc_st_data_o = r_data[r_head[IDX_W-1:0]];
  assign dc_st_be_o = r_be[r_head[IDX_W-1:0]];
  assign w_disp = dp_en_i && !w_full && !br_recover_i;
  assign w_retire = rob_st_retire_i && (r_commit != r_tail);
  assign w_drain = dc_st_ack_i && dc_st_req_o;
  assign w_disp_v = SQ_DEPTH'(w_disp) << r_tail[IDX_W-1:0];
  assign w_res_v = SQ_DEPTH'(st_vld_i) << st_idx_i;
  assign w_ret_v = SQ_DEPTH'(w_retire) << r_commit[IDX_W-1:0];
  assign w_drn_v = SQ_DEPTH'(w_drain) << r_head[IDX_W-1:0];
  // Squash window is [br_sq_tail_i, r_tail): offset of each entry from the checkpoint vs. window length
  always_comb begin
    w_sq_v = '0;
    for (int i = 0; i < SQ_DEPTH; i++)
      w_sq_v[i] = br_recover_i && ({1'b0, IDX_W'(i) - br_sq_tail_i[IDX_W-1:0]} < (r_tail - br_sq_tail_i));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head <= '0;
      r_commit <= '0;
      r_tail <= '0;
      r_addr_vld <= '0;
      r_retired <= '0;
    end else begin
      r_head <= r_head + PW'(w_drain);
      r_commit <= r_commit + PW'(w_retire);
      r_tail <= br_recover_i ? br_sq_tail_i : r_tail + PW'(w_disp);
      r_addr_vld <= ((r_addr_vld & ~w_disp_v) | w_res_v) & ~(w_sq_v | w_drn_v);
      r_retired <= ((r_retired & ~w_disp_v) | w_ret_v) & ~w_drn_v;
    end
  end
  always_ff @(posedge clk) begin
    if (st_vld_i) begin
      r_addr[st_idx_i] <= st_addr_i;
      r_data[st_idx_i] <= st_data_i;
      r_be[st_idx_i] <= st_be_i;
    end
    for (int i = 0; i < SQ_DEPTH; i++)
      r_br_mask[i] <= (w_disp_v[i] ? dp_br_mask_i : r_br_mask[i]) & ~(br_correct_i ? br_tag_i : '0);
  end
`ifdef SQ_STLD_FWD_EN
  logic w_fwd;
  logic [DATA_W-1:0] w_fdata;
`endif
  // Walk older entries youngest-first; the first address match with overlapping bytes decides the outcome
  always_comb begin
    w_unknown = 1'b0;
    w_conf = 1'b0;
    w_done = 1'b0;
    w_j = '0;
    w_n = ld_q_pos_i - r_head;
`ifdef SQ_STLD_FWD_EN
    w_fwd = 1'b0;
    w_fdata = '0;
`endif
    for (int k = 0; k < SQ_DEPTH; k++) begin
      w_j = ld_q_pos_i[IDX_W-1:0] - IDX_W'(k + 1);
      if (PW'(k) < w_n) begin
        w_unknown = w_unknown | !r_addr_vld[w_j];
        if (!w_done && (r_addr[w_j] == ld_q_addr_i) && |(r_be[w_j] & ld_q_be_i)) begin
          w_done = 1'b1;
`ifdef SQ_STLD_FWD_EN
          if ((r_be[w_j] & ld_q_be_i) == ld_q_be_i) begin
            w_fwd = 1'b1;
            w_fdata = r_data[w_j];
          end else
            w_conf = 1'b1;
`else
          w_conf = 1'b1;
`endif
        end
      end
    end
  end
  assign ld_older_unknown_o = ld_q_vld_i && w_unknown;
  assign ld_conflict_o = ld_q_vld_i && !w_unknown && w_conf;
`ifdef SQ_STLD_FWD_EN
  assign ld_fwd_vld_o = ld_q_vld_i && !w_unknown && w_fwd;
  assign ld_fwd_data_o = ld_fwd_vld_o ? w_fdata : '0;
`else
  assign ld_fwd_vld_o = 1'b0;
  assign ld_fwd_data_o = '0;
`endif
endmodule

// File: tb/tb_lsq_sq_param.sv
// tb_lsq_sq_param: directed scoreboard bench for lsq_sq_param at default parameters
module tb_lsq_sq_param;
`ifdef SQ_STLD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [63:0] DA = 64'hAABB_CCDD_1122_3344;
  logic clk = 1'b0;
  logic rst_n;
  logic dp_en_i;
  logic [3:0] dp_br_mask_i;
  logic [3:0] sq_tail_o;
  logic sq_full_o, sq_empty_o;
  logic st_vld_i;
  logic [2:0] st_idx_i;
  logic [63:0] st_addr_i, st_data_i;
  logic [7:0] st_be_i;
  logic rob_st_retire_i;
  logic dc_st_req_o;
  logic [63:0] dc_st_addr_o, dc_st_data_o;
  logic [7:0] dc_st_be_o;
  logic dc_st_ack_i;
  logic ld_q_vld_i;
  logic [63:0] ld_q_addr_i;
  logic [7:0] ld_q_be_i;
  logic [3:0] ld_q_pos_i;
  logic ld_older_unknown_o, ld_fwd_vld_o, ld_conflict_o;
  logic [63:0] ld_fwd_data_o;
  logic br_recover_i;
  logic [3:0] br_sq_tail_i;
  logic br_correct_i;
  logic [3:0] br_tag_i;
  lsq_sq_param dut (
    .clk(clk), .rst_n(rst_n),
    .dp_en_i(dp_en_i), .dp_br_mask_i(dp_br_mask_i),
    .sq_tail_o(sq_tail_o), .sq_full_o(sq_full_o), .sq_empty_o(sq_empty_o),
    .st_vld_i(st_vld_i), .st_idx_i(st_idx_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_be_i(st_be_i),
    .rob_st_retire_i(rob_st_retire_i),
    .dc_st_req_o(dc_st_req_o), .dc_st_addr_o(dc_st_addr_o), .dc_st_data_o(dc_st_data_o),
    .dc_st_be_o(dc_st_be_o), .dc_st_ack_i(dc_st_ack_i),
    .ld_q_vld_i(ld_q_vld_i), .ld_q_addr_i(ld_q_addr_i), .ld_q_be_i(ld_q_be_i), .ld_q_pos_i(ld_q_pos_i),
    .ld_older_unknown_o(ld_older_unknown_o), .ld_fwd_vld_o(ld_fwd_vld_o),
    .ld_fwd_data_o(ld_fwd_data_o), .ld_conflict_o(ld_conflict_o),
    .br_recover_i(br_recover_i), .br_sq_tail_i(br_sq_tail_i),
    .br_correct_i(br_correct_i), .br_tag_i(br_tag_i)
  );
  always #5 clk = ~clk;
  typedef struct {
    string tag;
    logic [63:0] v;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  task automatic expect_v(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    exp_q.push_back(e);
  endtask
  task automatic chk(input logic [63:0] obs);
    exp_t e;
    e = exp_q.pop_front();
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.v);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic res(input logic [2:0] idx, input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
    st_vld_i = 1'b1;
    st_idx_i = idx;
    st_addr_i = a;
    st_data_i = d;
    st_be_i = be;
    tick();
    st_vld_i = 1'b0;
  endtask
  task automatic ld_chk(input string t, input logic [3:0] pos, input logic [63:0] a, input logic [7:0] be,
                        input logic u, input logic f, input logic c, input logic [63:0] d);
    ld_q_vld_i = 1'b1;
    ld_q_pos_i = pos;
    ld_q_addr_i = a;
    ld_q_be_i = be;
    expect_v({t, ".unknown"}, 64'(u));
    expect_v({t, ".fwd_vld"}, 64'(f));
    expect_v({t, ".conflict"}, 64'(c));
    expect_v({t, ".fwd_data"}, d);
    #1;
    chk(64'(ld_older_unknown_o));
    chk(64'(ld_fwd_vld_o));
    chk(64'(ld_conflict_o));
    chk(ld_fwd_data_o);
    ld_q_vld_i = 1'b0;
  endtask
  task automatic occ(input string t, input logic [3:0] tail, input logic full, input logic empty, input logic req);
    expect_v({t, ".tail"}, 64'(tail));
    expect_v({t, ".full"}, 64'(full));
    expect_v({t, ".empty"}, 64'(empty));
    expect_v({t, ".dc_req"}, 64'(req));
  endtask
  task automatic occ_chk();
    chk(64'(sq_tail_o));
    chk(64'(sq_full_o));
    chk(64'(sq_empty_o));
    chk(64'(dc_st_req_o));
  endtask
  initial begin
    rst_n = 1'b0;
    dp_en_i = 1'b0;
    dp_br_mask_i = 4'b0011;
    st_vld_i = 1'b0;
    st_idx_i = '0;
    st_addr_i = '0;
    st_data_i = '0;
    st_be_i = '0;
    rob_st_retire_i = 1'b0;
    dc_st_ack_i = 1'b0;
    ld_q_vld_i = 1'b0;
    ld_q_addr_i = '0;
    ld_q_be_i = '0;
    ld_q_pos_i = '0;
    br_recover_i = 1'b0;
    br_sq_tail_i = '0;
    br_correct_i = 1'b0;
    br_tag_i = '0;
    tick();
    tick();
    rst_n = 1'b1;
    occ("reset", 4'd0, 1'b0, 1'b1, 1'b0);
    expect_v("reset.unknown", 0);
    expect_v("reset.fwd_vld", 0);
    expect_v("reset.conflict", 0);
    #1;
    occ_chk();
    chk(64'(ld_older_unknown_o));
    chk(64'(ld_fwd_vld_o));
    chk(64'(ld_conflict_o));
    dp_en_i = 1'b1;
    repeat (7) tick();
    occ("fill8", 4'b1000, 1'b1, 1'b0, 1'b0);
    tick();
    occ_chk();
    occ("disp_when_full", 4'b1000, 1'b1, 1'b0, 1'b0);
    tick();
    dp_en_i = 1'b0;
    occ_chk();
    res(3'd1, 64'h200, 64'h2222, 8'h0F);
    ld_chk("older_unknown", 4'd2, 64'h200, 8'hFF, 1'b1, 1'b0, 1'b0, 64'h0);
    res(3'd0, 64'h300, 64'h3333, 8'hFF);
    ld_chk("partial_conflict", 4'd2, 64'h200, 8'hFF, 1'b0, 1'b0, 1'b1, 64'h0);
    res(3'd2, 64'h100, DA, 8'hFF);
    ld_chk("full_cover", 4'd3, 64'h100, 8'h0F, 1'b0, FWD, !FWD, FWD ? DA : 64'h0);
    ld_chk("no_match", 4'd3, 64'h400, 8'hFF, 1'b0, 1'b0, 1'b0, 64'h0);
    ld_chk("pos_eq_head", 4'd0, 64'h100, 8'hFF, 1'b0, 1'b0, 1'b0, 64'h0);
    ld_chk("idx3_unresolved", 4'd4, 64'h100, 8'h0F, 1'b1, 1'b0, 1'b0, 64'h0);
    res(3'd3, 64'h100, 64'h4444, 8'hF0);
    ld_chk("skip_disjoint", 4'd4, 64'h100, 8'h0F, 1'b0, FWD, !FWD, FWD ? DA : 64'h0);
    ld_chk("youngest_partial", 4'd4, 64'h100, 8'hFF, 1'b0, 1'b0, 1'b1, 64'h0);
    ld_chk("all_older", 4'b1000, 64'h100, 8'hFF, 1'b1, 1'b0, 1'b0, 64'h0);
    rob_st_retire_i = 1'b1;
    tick();
    tick();
    rob_st_retire_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_v("hold.req", 1);
      expect_v("hold.addr", 64'h300);
      expect_v("hold.data", 64'h3333);
      chk(64'(dc_st_req_o));
      chk(dc_st_addr_o);
      chk(dc_st_data_o);
      tick();
    end
    dc_st_ack_i = 1'b1;
    expect_v("ack1.req", 1);
    expect_v("ack1.addr", 64'h200);
    expect_v("ack1.be", 64'h0F);
    tick();
    dc_st_ack_i = 1'b0;
    chk(64'(dc_st_req_o));
    chk(dc_st_addr_o);
    chk(64'(dc_st_be_o));
    dc_st_ack_i = 1'b1;
    occ("ack2", 4'b1000, 1'b0, 1'b0, 1'b0);
    tick();
    dc_st_ack_i = 1'b0;
    occ_chk();
    dc_st_ack_i = 1'b1;
    tick();
    dc_st_ack_i = 1'b0;
    br_recover_i = 1'b1;
    br_sq_tail_i = 4'd6;
    occ("recover6", 4'd6, 1'b0, 1'b0, 1'b0);
    tick();
    br_recover_i = 1'b0;
    occ_chk();
    ld_chk("pos6_unknown", 4'd6, 64'h500, 8'hFF, 1'b1, 1'b0, 1'b0, 64'h0);
    br_recover_i = 1'b1;
    br_sq_tail_i = 4'd3;
    dp_en_i = 1'b1;
    occ("recover3_vs_disp", 4'd3, 1'b0, 1'b0, 1'b0);
    tick();
    br_recover_i = 1'b0;
    dp_en_i = 1'b0;
    occ_chk();
    ld_chk("after_squash", 4'd3, 64'h100, 8'h0F, 1'b0, FWD, !FWD, FWD ? DA : 64'h0);
    ld_chk("squash_cleared", 4'd4, 64'h100, 8'h0F, 1'b1, 1'b0, 1'b0, 64'h0);
    br_recover_i = 1'b1;
    br_sq_tail_i = 4'd2;
    occ("recover2_empty", 4'd2, 1'b0, 1'b1, 1'b0);
    tick();
    br_recover_i = 1'b0;
    occ_chk();
    dp_en_i = 1'b1;
    br_correct_i = 1'b1;
    br_tag_i = 4'b0001;
    repeat (8) tick();
    dp_en_i = 1'b0;
    br_correct_i = 1'b0;
    occ("refill", 4'hA, 1'b1, 1'b0, 1'b0);
    #1;
    occ_chk();
    rob_st_retire_i = 1'b1;
    tick();
    rob_st_retire_i = 1'b0;
    dp_en_i = 1'b1;
    dc_st_ack_i = 1'b1;
    occ("drain_vs_disp", 4'hA, 1'b0, 1'b0, 1'b0);
    tick();
    dp_en_i = 1'b0;
    dc_st_ack_i = 1'b0;
    occ_chk();
    rst_n = 1'b0;
    occ("mid_reset", 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    rst_n = 1'b1;
    occ_chk();
    rob_st_retire_i = 1'b1;
    tick();
    rob_st_retire_i = 1'b0;
    dp_en_i = 1'b1;
    occ("bad_retire", 4'd1, 1'b0, 1'b0, 1'b0);
    tick();
    dp_en_i = 1'b0;
    occ_chk();
    rob_st_retire_i = 1'b1;
    expect_v("retire_after_disp.req", 1);
    tick();
    rob_st_retire_i = 1'b0;
    chk(64'(dc_st_req_o));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
